image_frame_packer: RTL and testbench

//  Source-side feeder for the 28x28 binary-image classifier.
//  - Accepts one image row per valid/ready handshake and assembles rows into a full frame.
//  - Presents the frame on a valid/ready interface whose data_o connects directly to the classifier's data_i.
//  - Sits between the pixel source (host/UART/memory reader) and the classifier input.

---
 rtl/image_frame_packer.sv | 150 +++++++++++++++
 tb/tb_image_frame_packer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_packer.sv
// Packs ROW_W-bit rows into one NUM_ROWS-row frame for the binary-image classifier.
// Latency: valid_o rises one cycle after the final row is accepted; rows go straight into the frame register.
// Backpressure: while a frame is pending, ready_o follows ready_i, so a row is accepted only when that frame leaves.
// Optional framing check: define IMAGE_FRAME_PACKER_SYNC_EN to add last_i/err_o.
module image_frame_packer #(
    parameter int ROW_W    = 28,
    parameter int NUM_ROWS = 28
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      valid_i,
    input  logic [ROW_W-1:0]          data_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [ROW_W*NUM_ROWS-1:0] data_o,
    input  logic                      ready_i
`ifdef IMAGE_FRAME_PACKER_SYNC_EN
    ,
    input  logic                      last_i,
    output logic                      err_o
`endif
);

    localparam int FRAME_W = ROW_W * NUM_ROWS;
    localparam int CNT_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_row_cnt;
    logic [CNT_W-1:0]   w_row_cnt_nxt;
    logic [FRAME_W-1:0] r_frame;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_wr_en;
    logic [CNT_W-1:0]   w_wr_slot;
`ifdef IMAGE_FRAME_PACKER_SYNC_EN
    logic               w_err_nxt;
    logic               r_err;
`endif

    // While a frame is pending the only way to accept a row is for the classifier to take the frame
    // in the same cycle, so ready_i passes straight through. Held low during reset.
    assign ready_o    = reset_ni & ((r_state == S_FILL) | ready_i);
    assign valid_o    = (r_state == S_FULL);
    assign data_o     = r_frame;
    assign w_in_fire  = valid_i & ready_o;
    assign w_out_fire = (r_state == S_FULL) & ready_i;

    // State and row counter registers
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state   <= S_FILL;
            r_row_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row_cnt <= w_row_cnt_nxt;
        end
    end

    // Next-state, row-slot write select and framing error detection
    always_comb begin
        w_state_nxt   = r_state;
        w_row_cnt_nxt = r_row_cnt;
        w_wr_en       = 1'b0;
        w_wr_slot     = r_row_cnt;
`ifdef IMAGE_FRAME_PACKER_SYNC_EN
        w_err_nxt     = 1'b0;
`endif
        case (r_state)
            S_FILL: begin
                if (w_in_fire) begin
                    w_wr_en   = 1'b1;
                    w_wr_slot = r_row_cnt;
                    if (r_row_cnt == LAST_ROW) begin
                        w_state_nxt   = S_FULL;
                        w_row_cnt_nxt = '0;
                    end else begin
                        w_row_cnt_nxt = r_row_cnt + CNT_W'(1);
                    end
`ifdef IMAGE_FRAME_PACKER_SYNC_EN
                    // Early last: abandon the partial frame and restart at slot 0.
                    if (last_i && (r_row_cnt != LAST_ROW)) begin
                        w_row_cnt_nxt = '0;
                        w_err_nxt     = 1'b1;
                    end
                    // Missing last: the frame is still complete, only flag it.
                    if (!last_i && (r_row_cnt == LAST_ROW)) begin
                        w_err_nxt = 1'b1;
                    end
`endif
                end
            end
            S_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt   = S_FILL;
                    w_row_cnt_nxt = '0;
                    // A row arriving with the frame release becomes row 0 of the next frame.
                    if (w_in_fire) begin
                        w_wr_en       = 1'b1;
                        w_wr_slot     = '0;
                        w_row_cnt_nxt = CNT_W'(1);
`ifdef IMAGE_FRAME_PACKER_SYNC_EN
                        if (last_i) begin
                            w_row_cnt_nxt = '0;
                            w_err_nxt     = 1'b1;
                        end
`endif
                    end
                end
            end
            default: begin
                w_state_nxt   = S_FILL;
                w_row_cnt_nxt = '0;
            end
        endcase
    end

    // Frame storage: the accepted row lands in its slot; other slots keep their old pixels
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_frame <= '0;
        end else if (w_wr_en) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (w_wr_slot == CNT_W'(r)) begin
                    r_frame[r*ROW_W +: ROW_W] <= data_i;
                end
            end
        end
    end

`ifdef IMAGE_FRAME_PACKER_SYNC_EN
    // One-cycle framing error pulse
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_image_frame_packer.sv
// Bench for image_frame_packer: reset/first-frame table, then model-checked sequences.
// Inputs change 1 time unit after posedge; outputs are compared on the falling edge.
// The model collects accepted rows in a queue and holds at most one pending frame.
module tb_image_frame_packer;

    localparam int ROW_W    = 28;
    localparam int NUM_ROWS = 28;
    localparam int FW       = ROW_W * NUM_ROWS;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic              valid_i;
    logic [ROW_W-1:0]  data_i;
    logic              ready_o;
    logic              valid_o;
    logic [FW-1:0]     data_o;
    logic              ready_i;
`ifdef IMAGE_FRAME_PACKER_SYNC_EN
    logic              last_i;
    logic              err_o;
`endif

    image_frame_packer #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS)) dut (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .valid_i  (valid_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .ready_i  (ready_i)
`ifdef IMAGE_FRAME_PACKER_SYNC_EN
        ,
        .last_i   (last_i),
        .err_o    (err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [ROW_W-1:0] m_rows[$];
    logic             m_pend;
    logic [FW-1:0]    m_frame;
    int               m_frames_out;
    logic             m_acc;

    typedef struct {
        logic             rst_n;
        logic             vld;
        logic [ROW_W-1:0] dat;
        logic             rdy;
        logic             x_rdy;
        logic             x_vld;
        logic [1:0]       x_chk;   // 0 none, 1 data_o all zero, 2 data_o equals frame 1
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t mkv(input logic rs, input logic v, input logic [ROW_W-1:0] d,
                                 input logic r, input logic xr, input logic xv, input logic [1:0] xc);
        vec_t t;
        t.rst_n = rs; t.vld = v; t.dat = d; t.rdy = r;
        t.x_rdy = xr; t.x_vld = xv; t.x_chk = xc;
        return t;
    endfunction

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0b exp=%0b", nm, got, exp);
        end
    endtask

    task automatic chkf(input string nm, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // One clock of stimulus, compared against the model, then the model advances.
    task automatic cyc(input logic rst, input logic v, input logic [ROW_W-1:0] d, input logic r);
        logic x_rdy;
        @(posedge clk_i); #1;
        reset_ni = rst; valid_i = v; data_i = d; ready_i = r;
        @(negedge clk_i);
        x_rdy = rst & (~m_pend | r);
        chk1("ready_o", ready_o, x_rdy);
        chk1("valid_o", valid_o, m_pend);
        if (m_pend) chkf("data_o", data_o, m_frame);
        m_acc = v & x_rdy;
        if (!rst) begin
            m_rows.delete();
            m_pend = 1'b0;
        end else begin
            if (m_pend && r) begin
                m_pend = 1'b0;
                m_frames_out++;
            end
            if (m_acc) begin
                m_rows.push_back(d);
                if (m_rows.size() == NUM_ROWS) begin
                    for (int i = 0; i < NUM_ROWS; i++) m_frame[i*ROW_W +: ROW_W] = m_rows[i];
                    m_pend = 1'b1;
                    m_rows.delete();
                end
            end
        end
    endtask

    initial begin
        logic [FW-1:0]    f1;
        logic [FW-1:0]    held;
        logic [FW-1:0]    cfr;
        logic [ROW_W-1:0] d;
        logic [ROW_W-1:0] ones;
        logic             cv;
        logic [ROW_W-1:0] cd;
        int               base;
        int               target;

        reset_ni = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
`ifdef IMAGE_FRAME_PACKER_SYNC_EN
        last_i = 1'b0;
`endif
        ones = '1;
        repeat (2) @(posedge clk_i);

        // Test 1: reset state, one frame of walking-one rows, release with ready_i=1
        f1 = '0;
        tbl[0] = mkv(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int k = 1; k <= NUM_ROWS; k++) begin
            d = ROW_W'(1) << ((k - 1) % ROW_W);
            f1[(k-1)*ROW_W +: ROW_W] = d;
            tbl[k] = mkv(1'b1, 1'b1, d, 1'b1, 1'b1, 1'b0, (k == 1) ? 2'd1 : 2'd0);
        end
        tbl[29] = mkv(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1, 2'd2);
        tbl[30] = mkv(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, 2'd0);
        for (int k = 0; k < 31; k++) begin
            @(posedge clk_i); #1;
            reset_ni = tbl[k].rst_n; valid_i = tbl[k].vld; data_i = tbl[k].dat; ready_i = tbl[k].rdy;
            @(negedge clk_i);
            chk1("t1_ready_o", ready_o, tbl[k].x_rdy);
            chk1("t1_valid_o", valid_o, tbl[k].x_vld);
            if (tbl[k].x_chk == 2'd1) chkf("t1_reset_data", data_o, '0);
            if (tbl[k].x_chk == 2'd2) chkf("t1_frame", data_o, f1);
        end

        m_rows.delete();
        m_pend = 1'b0;
        m_frames_out = 0;

        // Test 2: pending frame held under ready_i=0 while upstream keeps offering rows
        for (int k = 0; k < NUM_ROWS; k++) cyc(1'b1, 1'b1, ROW_W'($urandom()), 1'b0);
        held = m_frame;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1, 1'b1, ROW_W'($urandom()), 1'b0);
            chkf("t2_stable", data_o, held);
        end
        cyc(1'b1, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0);
        chki("t2_frames", m_frames_out, 1);

        // Test 3: back-to-back frames, all ones then all zeros, no bubble
        base = m_frames_out;
        for (int i = 0; i <= 2 * NUM_ROWS; i++) begin
            cyc(1'b1, 1'b1, (i < NUM_ROWS) ? ones : '0, 1'b1);
            if (i == NUM_ROWS) begin
                chk1("t3_A_valid", valid_o, 1'b1);
                chkf("t3_A_data", data_o, {NUM_ROWS{ones}});
            end
            if (i == 2 * NUM_ROWS) begin
                chk1("t3_B_valid", valid_o, 1'b1);
                chkf("t3_B_data", data_o, '0);
            end
        end
        chki("t3_frames", m_frames_out, base + 2);

        // Test 4: reset after 13 rows, then a clean frame C; then reset while C is pending
        for (int k = 0; k < 13; k++) cyc(1'b1, 1'b1, ROW_W'($urandom()), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0);
        chkf("t4_reset_data", data_o, '0);
        for (int k = 0; k < NUM_ROWS; k++) begin
            d = ROW_W'($urandom());
            cfr[k*ROW_W +: ROW_W] = d;
            cyc(1'b1, 1'b1, d, 1'b0);
        end
        cyc(1'b1, 1'b0, '0, 1'b0);
        chkf("t4_C_data", data_o, cfr);
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        chk1("t4_dropped", valid_o, 1'b0);

        // Test 5: random stalls on both sides, 20 frames through the scoreboard
        target = m_frames_out + 20;
        cv = 1'b0;
        cd = '0;
        m_acc = 1'b0;
        for (int c = 0; c < 6000 && m_frames_out < target; c++) begin
            if (!cv || m_acc) begin
                cv = 1'($urandom_range(0, 1));
                cd = ROW_W'($urandom());
            end
            cyc(1'b1, cv, cd, 1'($urandom_range(0, 1)));
        end
        chki("t5_frames", m_frames_out, target);

`ifdef IMAGE_FRAME_PACKER_SYNC_EN
        // Test 6: early last drops the partial frame; a correctly marked frame is clean
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
            valid_i = 1'b1; data_i = ROW_W'(k); last_i = (k == 5); ready_i = 1'b0;
            @(negedge clk_i);
            chk1("t6_err_idle", err_o, 1'b0);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0; last_i = 1'b0;
        @(negedge clk_i);
        chk1("t6_err_early", err_o, 1'b1);
        chk1("t6_no_frame", valid_o, 1'b0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk1("t6_err_clear", err_o, 1'b0);
        for (int k = 0; k < NUM_ROWS; k++) begin
            d = ROW_W'($urandom());
            cfr[k*ROW_W +: ROW_W] = d;
            @(posedge clk_i); #1;
            valid_i = 1'b1; data_i = d; last_i = (k == NUM_ROWS - 1);
            @(negedge clk_i);
            chk1("t6_err_fill", err_o, 1'b0);
            chk1("t6_valid_fill", valid_o, 1'b0);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0; last_i = 1'b0;
        @(negedge clk_i);
        chk1("t6_valid", valid_o, 1'b1);
        chk1("t6_err_clean", err_o, 1'b0);
        chkf("t6_data", data_o, cfr);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
